// File: rtl/pkg.sv
// Shared types for the intf2 producer/consumer slice.
//   type_2_t     : two-field word carried on intf2 (abc, def)
//   drv_state_t  : presentation FSM state of intf2_all_out_driver
package pkg;

  typedef struct packed {
    logic abc;
    logic def;
  } type_2_t;

  typedef enum logic {IDLE, HOLD} drv_state_t;

  localparam int unsigned DRV_DEFAULT_DEPTH = 4;

endpackage

// File: rtl/intf2.sv
// intf2: two single-bit lanes, abc and def.
//   all_out : producer side, drives abc/def
//   all_in  : consumer side, observes abc/def
interface intf2;
  logic abc;
  logic def;

  modport all_out (output abc, output def);
  modport all_in  (input  abc, input  def);
endinterface

// File: rtl/intf2_drv_fifo.sv
// Synchronous FIFO of type_2_t words feeding the intf2 driver.
//   clk, rst     : clock, synchronous active-high reset (flushes pointers/level)
//   push, wdata  : write strobe and word (ignored when full)
//   pop, rdata   : read strobe and head word (rdata valid while !empty)
//   full, empty  : occupancy flags
//   level        : occupancy 0..DEPTH
module intf2_drv_fifo
  import pkg::*;
#(
  parameter int unsigned DEPTH = DRV_DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  type_2_t                      wdata,
  input  logic                         pop,
  output type_2_t                      rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);

  type_2_t            mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; only pointers and level define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/intf2_all_out_driver.sv
// Producer stage driving intf2 through its all_out modport. Words are queued
// in a small FIFO and each is held on abc/def for hold_cycles+1 cycles,
// back-to-back while data is queued.
//   clk, rst      : clock, synchronous active-high reset
//   in_valid/in_ready/in_data : input handshake (push on valid && ready)
//   hold_cycles   : extra presentation cycles, sampled when a word is loaded
//   out_port      : intf2.all_out, abc/def registered
//   busy          : a word is being presented (HOLD)
//   level         : FIFO occupancy
//   word_done     : high on the final presentation cycle of each word
module intf2_all_out_driver
  import pkg::*;
#(
  parameter int unsigned DEPTH  = DRV_DEFAULT_DEPTH,
  parameter int unsigned HOLD_W = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  type_2_t                      in_data,
  input  logic [HOLD_W-1:0]            hold_cycles,
  intf2.all_out                        out_port,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         word_done
);

  drv_state_t         state;
  logic [HOLD_W-1:0]  hold_cnt;
  type_2_t            fifo_rdata;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic               last_cycle;

  // No bypass: a full FIFO refuses even when a pop happens this cycle.
  assign in_ready   = !fifo_full && !rst;
  assign push       = in_valid && in_ready;
  assign last_cycle = (state == HOLD) && (hold_cnt == '0);
  // Pop from IDLE, or on the last cycle of a word for zero-gap streaming.
  assign pop        = !fifo_empty && ((state == IDLE) || last_cycle);
  assign busy       = (state == HOLD);
  assign word_done  = last_cycle;

  intf2_drv_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  // Presentation FSM; abc/def retain the last word while IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      out_port.abc <= 1'b0;
      out_port.def <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            out_port.abc <= fifo_rdata.abc;
            out_port.def <= fifo_rdata.def;
            hold_cnt     <= hold_cycles;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end else if (!fifo_empty) begin
            out_port.abc <= fifo_rdata.abc;
            out_port.def <= fifo_rdata.def;
            hold_cnt     <= hold_cycles;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/intf2_all_out_driver.md
Name: intf2_all_out_driver

Overview:
- Producer stage that drives an intf2 instance through its all_out modport.
- Feeds the downstream consumer bound to the all_in modport, and the intf2 ports of sub_w_intf.
- Accepts pkg::type_2_t words on a valid/ready input and buffers them in a small FIFO.
- Presents each word on abc/def for a programmable number of cycles, back-to-back when data is queued.

Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- HOLD_W, 4: width of the hold_cycles field.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  2 (pkg::type_2_t)  word; .abc and .def fields.
- hold_cycles  input  HOLD_W  extra cycles each word stays on the bus; sampled at load.
- out_port  interface  intf2.all_out  drives abc and def.
- busy  output  1  a word is currently being presented (state HOLD).
- level  output  $clog2(DEPTH+1)  FIFO occupancy.
- word_done  output  1  one-cycle pulse on the final presentation cycle of each word.

Behaviour:
- Reset (rst=1 at an edge):
  - FIFO flushed; level=0; in_ready=0 while rst is high, 1 on the first cycle after rst deasserts.
  - out_port.abc=0, out_port.def=0, busy=0, word_done=0, FSM in IDLE.
  - Applies identically mid-operation: the in-flight word is dropped and outputs return to 0 on the edge following rst.
- Input handshake:
  - Push when in_valid && in_ready.
  - in_ready = !full && !rst; no bypass of a full FIFO, even if a pop happens in the same cycle.
  - in_data may change freely while in_ready=0.
- FIFO:
  - Read/write pointers of $clog2(DEPTH) bits wrap modulo DEPTH.
  - level counts 0..DEPTH; push and pop in the same cycle leave level unchanged.
  - Full when level==DEPTH; empty when level==0.
- FSM states: IDLE, HOLD (enum in the shared package).
  - IDLE: if !empty, pop the head, load abc/def and hold_cnt<=hold_cycles, go to HOLD.
  - HOLD, hold_cnt!=0: hold_cnt decrements.
  - HOLD, hold_cnt==0: word_done=1 this cycle. If !empty, pop and load the next word on this edge and stay in HOLD (zero-gap back-to-back); else go to IDLE.
- Output timing:
  - Each word is presented for exactly hold_cycles+1 cycles.
  - Latency from an accepted push into an empty FIFO with the FSM in IDLE to abc/def update: 2 edges.
- Output retention: in IDLE, abc/def keep the last presented word and are never cleared except by reset.
- Flags: busy=1 iff state==HOLD. word_done is combinational from state==HOLD && hold_cnt==0.
- Width rules:
  - hold_cnt is HOLD_W bits; hold_cycles=2^HOLD_W-1 gives the maximum 2^HOLD_W cycles.
  - hold_cycles=0 gives one cycle per word, with word_done high every cycle of a back-to-back stream.
- Boundary case, empty FIFO at the last cycle of a word: a push accepted on that same edge is not visible until the next cycle, so the FSM goes IDLE for at least one cycle before the next word.

Decomposition:
- Package pkg gains:
  - typedef enum logic {IDLE, HOLD} drv_state_t;
  - localparam int unsigned DRV_DEFAULT_DEPTH = 4.
- type_2_t is reused from pkg as the FIFO word type.
- One sub-module, intf2_drv_fifo: synchronous FIFO of type_2_t.
  - Parameter DEPTH.
  - Ports clk, rst, push, wdata, pop, rdata, full, empty, level.
- The top keeps the FSM, the hold counter and the modport drive.

Test Plan:
- Reset then idle, no valids: abc=0, def=0, busy=0, level=0; in_ready=0 during rst and 1 on the first cycle after.
- Single push {abc=1, def=0} with hold_cycles=2: abc=1 from edge +2 for exactly 3 cycles; word_done on the 3rd cycle; then IDLE with abc=1 retained.
- Push 4 words back-to-back with hold_cycles=0, DEPTH=4: no bubbles; words appear in order 1/cycle; word_done high for 4 consecutive cycles.
- Fill to full, hold_cycles=7: in_ready=0 at level=4; push attempts ignored; in_ready returns to 1 the cycle after the first pop; pointer wrap preserves order across 6 total words.
- hold_cycles=15 (HOLD_W=4): word presented for exactly 16 cycles; a hold_cycles change mid-word does not affect the current word.
- Assert rst in the middle of a HOLD with 3 words queued: next cycle abc=def=0, level=0, busy=0; the first push after reset presents the new word, not the old queue.
